aluv_sequencer: RTL and testbench
=================================

ALUV_SEQUENCER -- requirements
Module: aluv_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 8, element width (documentation only); LANES 6, ALU lanes per pass; SELECTOR_SIZE 3, ALU op-select width; MAX_CHUNKS 4, max passes per vector; LEN_WIDTH 5, vector-length field width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a vector operation; sampled only in IDLE.
REQ-005 op  input  SELECTOR_SIZE  ALU operation code; latched on start acceptance.
REQ-006 length  input  LEN_WIDTH  element count; legal range 1..LANES*MAX_CHUNKS (24).
REQ-007 abort  input  1  cancel the operation in progress.
REQ-008 busy  output  1  high in READ and EXEC.
REQ-009 done  output  1  one-cycle pulse on normal completion.
REQ-010 error  output  1  one-cycle pulse on an illegal-length start.
REQ-011 rd_en / rd_chunk  output  1 / 2  operand-memory read strobe and chunk index; memory returns operands to ALUV one cycle later.
REQ-012 alu_selector  output  SELECTOR_SIZE  drives the ALUV selector.
REQ-013 alu_mask  output  LANES  drives the ALUV vectorMask; bit i = lane i.
REQ-014 alu_cmp  input  LANES  ALUV outComparison, combinational from the current operands.
REQ-015 wr_en / wr_chunk / wr_mask  output  1 / 2 / LANES  result write-back strobe, chunk index and lane enables.
REQ-016 cmp_flags  output  LANES*MAX_CHUNKS  accumulated comparison bits; element e at bit e.

Function
REQ-017 FSM states SHALL be IDLE, READ, EXEC, DONE.
REQ-018 IDLE: start with legal length -> READ; latch op and length, set chunk k=0, clear cmp_flags.
REQ-019 IDLE: start with length 0 or >24 -> error=1 for the next cycle only, stay IDLE, cmp_flags unchanged.
REQ-020 READ: rd_en=1, rd_chunk=k for exactly one cycle -> EXEC.
REQ-021 EXEC: alu_selector=latched op; alu_mask=wr_mask=lanes i with k*LANES+i < length; wr_en=1; wr_chunk=k.
REQ-022 EXEC: cmp_flags[k*LANES+i] <= alu_cmp[i] & alu_mask[i]; masked-off bits SHALL stay 0.
REQ-023 EXEC, not last chunk -> READ with k+1; last chunk (k = ceil(length/LANES)-1) -> DONE.
REQ-024 DONE: done=1 for one cycle -> IDLE; cmp_flags held until the next accepted start or reset.
REQ-025 Timing: with start accepted in cycle 0 and N=ceil(length/6), chunk k is READ in cycle 2k+1 and EXEC in cycle 2k+2, and done is high in cycle 2N+1.
REQ-026 Outside EXEC, alu_selector SHALL be 0 and alu_mask, wr_en and wr_mask SHALL be 0; rd_en SHALL be 0 outside READ.
REQ-027 start SHALL be ignored in READ, EXEC and DONE; there is no queuing.
REQ-028 abort in READ or EXEC: in that cycle rd_en and wr_en SHALL be forced to 0, and cmp_flags SHALL not be updated; next state IDLE; no done.
REQ-029 abort SHALL have priority over every transition; abort in IDLE or DONE SHALL have no effect.
REQ-030 A length that is an exact multiple of 6 SHALL produce an all-ones mask on the last chunk.

Reset
REQ-031 reset SHALL force IDLE, k=0, latched op/length=0, cmp_flags=0, and every output to 0 on the next edge, including mid-operation; reset has priority over abort and start.

Verification
REQ-032 length=6, op=0 -> one EXEC with mask 111111 in cycle 2; done in cycle 3; busy high in cycles 1-2.
REQ-033 length=14, alu_cmp=111111 -> masks 111111, 111111, 000011 on chunks 0-2; done in cycle 7; cmp_flags=0x003FFF.
REQ-034 length=0, then length=25 -> an error pulse for each, no rd_en, wr_en or done, and the state remains IDLE.
REQ-035 start pulsed during EXEC of a length-12 run -> ignored; exactly 2 chunk writes; done in cycle 5.
REQ-036 abort in cycle 3 (READ, chunk 1) of a length-18 run -> rd_en=0 in cycle 3; IDLE in cycle 4; no done; cmp_flags holds chunk-0 bits only.
REQ-037 reset in cycle 2 of a length-24 run -> all outputs and cmp_flags 0 in cycle 3; a new start in cycle 3 completes normally.

Source files
------------

// File: rtl/aluv_sequencer.sv
// Purpose : sequences a vector ALU over up to MAX_CHUNKS passes of LANES elements, collecting compare bits.
// Latency : start accepted in cycle 0 -> chunk k READ in cycle 2k+1, EXEC in 2k+2, done in cycle 2N+1.
// Backpres: none; start is ignored while an operation is in flight (no queuing), abort cancels at once.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   start_i, op_i, length_i  request, ALU op code and element count (legal 1..LANES*MAX_CHUNKS)
//   abort_i                  cancel the operation in progress (READ/EXEC only)
//   busy_o, done_o, error_o  status: in flight, completion pulse, illegal-length pulse
//   rd_en_o, rd_chunk_o      operand-memory read strobe and chunk index
//   alu_selector_o, alu_mask_o, alu_cmp_i   ALU op select, lane mask, per-lane compare result
//   wr_en_o, wr_chunk_o, wr_mask_o          result write-back strobe, chunk index, lane enables
//   cmp_flags_o              accumulated compare bits, element e at bit e
module aluv_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int LANES         = 6,
    parameter int SELECTOR_SIZE = 3,
    parameter int MAX_CHUNKS    = 4,
    parameter int LEN_WIDTH     = 5
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [SELECTOR_SIZE-1:0]      op_i,
    input  logic [LEN_WIDTH-1:0]          length_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic                          rd_en_o,
    output logic [$clog2(MAX_CHUNKS)-1:0] rd_chunk_o,
    output logic [SELECTOR_SIZE-1:0]      alu_selector_o,
    output logic [LANES-1:0]              alu_mask_o,
    input  logic [LANES-1:0]              alu_cmp_i,
    output logic                          wr_en_o,
    output logic [$clog2(MAX_CHUNKS)-1:0] wr_chunk_o,
    output logic [LANES-1:0]              wr_mask_o,
    output logic [LANES*MAX_CHUNKS-1:0]   cmp_flags_o
);
    localparam int CW      = $clog2(MAX_CHUNKS);
    localparam int MAX_LEN = LANES * MAX_CHUNKS;

    typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

    state_t                      state_q;
    logic [CW-1:0]               k_q;
    logic [SELECTOR_SIZE-1:0]    op_q;
    logic [LEN_WIDTH-1:0]        len_q;
    logic [LANES*MAX_CHUNKS-1:0] cmp_q;
    logic                        busy_q, done_q, error_q, rd_en_q, wr_en_q;
    logic [SELECTOR_SIZE-1:0]    sel_q;
    logic [LANES-1:0]            mask_q;

    logic                        len_legal;
    logic                        last_chunk;
    logic [LANES-1:0]            mask_d;

    assign len_legal  = (int'(length_i) != 0) && (int'(length_i) <= MAX_LEN);
    assign last_chunk = ((int'(k_q) + 1) * LANES) >= int'(len_q);

    // Lane i of chunk k is live when its element index is below the vector length.
    always_comb begin
        mask_d = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_d[i] = (int'(k_q) * LANES + i) < int'(len_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            op_q    <= '0;
            len_q   <= '0;
            cmp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            sel_q   <= '0;
            mask_q  <= '0;
        end else begin
            // Output registers default to their idle values; each state sets what the next cycle shows.
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            sel_q   <= '0;
            mask_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_legal) begin
                            state_q <= READ;
                            op_q    <= op_i;
                            len_q   <= length_i;
                            k_q     <= '0;
                            cmp_q   <= '0;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                        wr_en_q <= 1'b1;
                        sel_q   <= op_q;
                        mask_q  <= mask_d;
                    end
                end
                EXEC: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else begin
                        cmp_q[int'(k_q)*LANES +: LANES] <= alu_cmp_i & mask_q;
                        if (last_chunk) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            k_q     <= k_q + 1'b1;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Abort must kill the memory strobes in the very cycle it is seen, so it gates them directly.
    assign rd_en_o        = rd_en_q & ~abort_i;
    assign wr_en_o        = wr_en_q & ~abort_i;
    assign rd_chunk_o     = k_q;
    assign wr_chunk_o     = k_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign alu_selector_o = sel_q;
    assign alu_mask_o     = mask_q;
    assign wr_mask_o      = mask_q;
    assign cmp_flags_o    = cmp_q;

endmodule

// File: tb/tb_aluv_sequencer.sv
// Purpose : self-checking bench for aluv_sequencer against a cycle-indexed reference model.
// Latency : model predicts READ at 2k+1, EXEC at 2k+2, done at 2N+1 after the start cycle.
// Backpres: not applicable; the bench drives start/abort/reset directly.
module tb_aluv_sequencer;
    logic        clk_i = 1'b0;
    logic        reset_i, start_i, abort_i;
    logic [2:0]  op_i;
    logic [4:0]  length_i;
    logic        busy_o, done_o, error_o, rd_en_o, wr_en_o;
    logic [1:0]  rd_chunk_o, wr_chunk_o;
    logic [2:0]  alu_selector_o;
    logic [5:0]  alu_mask_o, alu_cmp_i, wr_mask_o;
    logic [23:0] cmp_flags_o;

    int checks = 0;
    int passed = 0;
    logic [23:0] model_flags;

    aluv_sequencer dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .length_i(length_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .rd_en_o(rd_en_o), .rd_chunk_o(rd_chunk_o),
        .alu_selector_o(alu_selector_o), .alu_mask_o(alu_mask_o), .alu_cmp_i(alu_cmp_i),
        .wr_en_o(wr_en_o), .wr_chunk_o(wr_chunk_o), .wr_mask_o(wr_mask_o),
        .cmp_flags_o(cmp_flags_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Expected outputs for one cycle, all in a single call.
    task automatic expect_all(input string tag, input logic busy, input logic done, input logic err,
                              input logic rd, input int rdch, input logic wr, input int wrch,
                              input int sel, input logic [5:0] mask);
        check({tag, ".busy"}, 32'(busy_o), 32'(busy));
        check({tag, ".done"}, 32'(done_o), 32'(done));
        check({tag, ".error"}, 32'(error_o), 32'(err));
        check({tag, ".rd_en"}, 32'(rd_en_o), 32'(rd));
        if (rd) check({tag, ".rd_chunk"}, 32'(rd_chunk_o), 32'(rdch));
        check({tag, ".wr_en"}, 32'(wr_en_o), 32'(wr));
        if (wr) check({tag, ".wr_chunk"}, 32'(wr_chunk_o), 32'(wrch));
        check({tag, ".sel"}, 32'(alu_selector_o), 32'(sel));
        check({tag, ".alu_mask"}, 32'(alu_mask_o), 32'(mask));
        check({tag, ".wr_mask"}, 32'(wr_mask_o), 32'(mask));
        check({tag, ".cmp_flags"}, 32'(cmp_flags_o), 32'(model_flags));
    endtask

    // Elements of chunk k that fall inside the vector.
    function automatic logic [5:0] lane_mask(input int k, input int len);
        logic [5:0] m = '0;
        for (int i = 0; i < 6; i++) if (k * 6 + i < len) m[i] = 1'b1;
        return m;
    endfunction

    // Runs one vector operation starting in the current cycle (cycle 0).
    // abort_cyc / start_cyc: cycle at which abort or a stray start is pulsed (-1 = never).
    // cmp_fix >= 0 forces that alu_cmp value every cycle, otherwise random.
    task automatic run_op(input string tag, input int len, input int opv,
                          input int abort_cyc, input int start_cyc, input int cmp_fix);
        int n = (len + 5) / 6;
        int writes = 0;
        logic [5:0] cmp, m;
        int k;
        start_i = 1'b1; op_i = 3'(opv); length_i = 5'(len); abort_i = 1'b0;
        alu_cmp_i = 6'($urandom);
        #1;
        expect_all({tag, ".c0"}, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
        step();
        start_i = 1'b0;
        model_flags = '0;
        for (int t = 1; t <= 2 * n + 1; t++) begin
            cmp = (cmp_fix >= 0) ? 6'(cmp_fix) : 6'($urandom);
            alu_cmp_i = cmp;
            abort_i = (t == abort_cyc);
            start_i = (t == start_cyc);
            op_i = 3'($urandom);
            length_i = 5'($urandom);
            #1;
            if (t == 2 * n + 1) begin
                expect_all($sformatf("%s.c%0d", tag, t), 0, 1, 0, 0, 0, 0, 0, 0, 6'b0);
            end else if (t % 2 == 1) begin
                k = (t - 1) / 2;
                expect_all($sformatf("%s.c%0d", tag, t), 1, 0, 0, !abort_i, k, 0, 0, 0, 6'b0);
            end else begin
                k = (t - 2) / 2;
                m = lane_mask(k, len);
                expect_all($sformatf("%s.c%0d", tag, t), 1, 0, 0, 0, 0, !abort_i, k, opv, m);
                if (!abort_i) begin
                    writes++;
                    for (int i = 0; i < 6; i++) model_flags[k * 6 + i] = cmp[i] & m[i];
                end
            end
            step();
            abort_i = 1'b0;
            start_i = 1'b0;
            if (t == abort_cyc) begin
                #1;
                expect_all({tag, ".post_abort"}, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
                return;
            end
        end
        #1;
        expect_all({tag, ".post_done"}, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
        check({tag, ".writes"}, 32'(writes), 32'(n));
    endtask

    task automatic bad_start(input string tag, input int len);
        start_i = 1'b1; length_i = 5'(len); op_i = 3'd5; abort_i = 1'b0;
        #1;
        expect_all({tag, ".c0"}, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
        step();
        start_i = 1'b0;
        #1;
        expect_all({tag, ".c1"}, 0, 0, 1, 0, 0, 0, 0, 0, 6'b0);
        step();
        #1;
        expect_all({tag, ".c2"}, 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; op_i = '0; length_i = '0; alu_cmp_i = '0;
        model_flags = '0;
        step(); step();
        expect_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
        reset_i = 1'b0;
        step();

        // Single full chunk, then partial last chunk with all compares true.
        run_op("len6", 6, 0, -1, -1, -1);
        run_op("len14", 14, 3, -1, -1, 6'h3F);
        check("len14.flags_value", 32'(cmp_flags_o), 32'h003FFF);

        // Illegal lengths: error pulse, no activity, flags kept.
        bad_start("len0", 0);
        bad_start("len25", 25);
        check("bad.flags_kept", 32'(cmp_flags_o), 32'h003FFF);

        // Stray start during EXEC is ignored; abort during READ of chunk 1.
        run_op("len12_start", 12, 6, -1, 2, -1);
        run_op("len18_abort", 18, 2, 3, -1, -1);
        run_op("len24_abort_exec", 24, 1, 4, -1, -1);

        // Reset mid-run, then a fresh start completes normally.
        start_i = 1'b1; op_i = 3'd7; length_i = 5'd24; alu_cmp_i = 6'h2A;
        step();
        start_i = 1'b0;
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        model_flags = '0;
        #1;
        expect_all("midreset", 0, 0, 0, 0, 0, 0, 0, 0, 6'b0);
        run_op("after_reset", 24, 4, -1, -1, -1);

        // Randomised runs across the legal length range.
        for (int r = 0; r < 20; r++) begin
            int len = $urandom_range(1, 24);
            int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * ((len + 5) / 6)) : -1;
            run_op($sformatf("rnd%0d", r), len, $urandom_range(0, 7), ab, -1, -1);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
